gr_stats: RTL and testbench
===========================

GR_STATS -- requirements
Module: gr_stats

Interface
REQ-001 Parameter LOG2_N, default 10: log2 of samples per measurement window (N = 2^LOG2_N); legal range 1..16.
REQ-002 Parameter DW, default 12: sample width, matching the gaus_rand gr output.
REQ-003 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 gr  input  DW  unsigned sample from the random-number generator.
REQ-006 gr_valid  input  1  sample on gr is valid this cycle.
REQ-007 start  input  1  single-cycle request to begin a measurement window.
REQ-008 busy  output  1  high while in ACC.
REQ-009 res_valid  output  1  results stable and valid; high in HOLD only.
REQ-010 res_ack  input  1  consumer has taken results.
REQ-011 sum  output  DW+LOG2_N  sum of window samples.
REQ-012 sumsq  output  2*DW+LOG2_N  sum of squared window samples.
REQ-013 mean  output  DW  sum >> LOG2_N (truncating).
REQ-014 min_s / max_s  output  DW each  smallest / largest sample in window.

Function
REQ-015 FSM states IDLE, ACC, HOLD; reset state IDLE.
REQ-016 IDLE: on start go to ACC; on the same edge clear sum, sumsq and count to 0, set min_s to all-ones and max_s to 0.
REQ-017 ACC: each cycle with gr_valid=1, sum += gr, sumsq += gr*gr (full 2*DW product), min_s/max_s update, count += 1; cycles with gr_valid=0 change nothing.
REQ-018 ACC: the sample that makes count = N is accumulated, and the FSM enters HOLD on the same edge; res_valid is high the following cycle (1-cycle latency from the last sample).
REQ-019 HOLD: all result outputs frozen; gr_valid is ignored; res_valid stays high until res_ack.
REQ-020 HOLD with res_ack=1, start=0 -> IDLE; HOLD with res_ack=1 and start=1 in the same cycle -> ACC with accumulators cleared (back-to-back windows).
REQ-021 start in ACC is ignored, as is start in HOLD without res_ack; res_ack outside HOLD is ignored.
REQ-022 Accumulator widths are sized so that N full-scale samples cannot overflow; there is no saturation logic.
REQ-023 count width is LOG2_N+1; it never wraps within a window.
REQ-024 Result outputs keep their last values in IDLE until the next start clears them.

Reset
REQ-025 rst=1 forces state IDLE, busy=0, res_valid=0, sum=0, sumsq=0, count=0, min_s=all-ones, max_s=0 on the next edge.
REQ-026 rst has priority over start, gr_valid and res_ack; rst mid-ACC or mid-HOLD aborts the window with no res_valid pulse.

Structure
REQ-027 A shared header gr_stats_defs holds the state encodings (IDLE=2'd0, ACC=2'd1, HOLD=2'd2) and the default LOG2_N and DW.
REQ-028 The design is a single module with no sub-modules; the squarer is an inferred DW x DW multiply.

Verification
REQ-029 LOG2_N=2, start, then samples 0x001, 0x002, 0x003, 0x004 -> res_valid one cycle after the 4th sample; sum=10, sumsq=30, mean=2, min_s=1, max_s=4.
REQ-030 LOG2_N=2, four samples of 0xFFF -> sum=0x3FFC, sumsq=4*0xFFE001=0x3FF8004, mean=0xFFF, no overflow.
REQ-031 gr_valid gaps (valid every 3rd cycle) -> same results as back-to-back samples; busy stays high throughout.
REQ-032 In HOLD, drive res_ack=1 and start=1 together -> next cycle busy=1, res_valid=0, sum=0; second window completes correctly.
REQ-033 rst after 2 of 4 samples -> all outputs at reset values; no res_valid; a fresh start completes normally.
REQ-034 gaus_rand connected, LOG2_N=10 -> mean within ±2% of the generator's nominal centre (0x800); min_s <= mean <= max_s.

Source files
------------

// File: rtl/gr_stats_pkg.sv
// Shared definitions for the gr_stats window-statistics block: FSM encodings
// and default sizing.
package gr_stats_pkg;

  localparam int GR_LOG2_N_DEF = 10;
  localparam int GR_DW_DEF     = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/gr_stats.sv
// Accumulates sum, sum of squares, min and max over a window of 2^LOG2_N
// random-generator samples, then holds the results until acknowledged.
module gr_stats
  import gr_stats_pkg::*;
#(
  parameter int LOG2_N = GR_LOG2_N_DEF,
  parameter int DW     = GR_DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            gr,
  input  logic                     gr_valid,
  input  logic                     start,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic [DW+LOG2_N-1:0]     sum,
  output logic [2*DW+LOG2_N-1:0]   sumsq,
  output logic [DW-1:0]            mean,
  output logic [DW-1:0]            min_s,
  output logic [DW-1:0]            max_s
);

  // Last sample index; the sample arriving at this count closes the window.
  localparam logic [LOG2_N:0] CNT_LAST = {1'b0, {LOG2_N{1'b1}}};

  logic [1:0]        state;
  logic [LOG2_N:0]   count;
  logic [2*DW-1:0]   sq;

  function automatic logic [DW-1:0] trunc_mean(input logic [DW+LOG2_N-1:0] s);
    return s[DW+LOG2_N-1:LOG2_N];
  endfunction

  assign sq        = {{DW{1'b0}}, gr} * {{DW{1'b0}}, gr};
  assign busy      = (state == ST_ACC);
  assign res_valid = (state == ST_HOLD);
  assign mean      = trunc_mean(sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      sum   <= '0;
      sumsq <= '0;
      min_s <= '1;
      max_s <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACC;
            count <= '0;
            sum   <= '0;
            sumsq <= '0;
            min_s <= '1;
            max_s <= '0;
          end
        end
        ST_ACC: begin
          if (gr_valid) begin
            sum   <= sum + {{LOG2_N{1'b0}}, gr};
            sumsq <= sumsq + {{LOG2_N{1'b0}}, sq};
            count <= count + 1'b1;
            if (gr < min_s) min_s <= gr;
            if (gr > max_s) max_s <= gr;
            if (count == CNT_LAST) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Ack with a simultaneous start chains straight into the next window.
          if (res_ack) begin
            if (start) begin
              state <= ST_ACC;
              count <= '0;
              sum   <= '0;
              sumsq <= '0;
              min_s <= '1;
              max_s <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gr_stats.sv
// Directed bench for gr_stats with a 4-sample window and 12-bit samples.
module tb_gr_stats;

  localparam int LOG2_N = 2;
  localparam int DW     = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DW-1:0]           gr;
  logic                    gr_valid;
  logic                    start;
  logic                    busy;
  logic                    res_valid;
  logic                    res_ack;
  logic [DW+LOG2_N-1:0]    sum;
  logic [2*DW+LOG2_N-1:0]  sumsq;
  logic [DW-1:0]           mean;
  logic [DW-1:0]           min_s;
  logic [DW-1:0]           max_s;

  int tests  = 0;
  int failed = 0;

  gr_stats #(.LOG2_N(LOG2_N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .gr(gr), .gr_valid(gr_valid), .start(start),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
    .sum(sum), .sumsq(sumsq), .mean(mean), .min_s(min_s), .max_s(max_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [DW-1:0] v);
    gr = v;
    gr_valid = 1'b1;
    tick();
    gr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input logic [63:0] s, input logic [63:0] sq,
                             input logic [63:0] m, input logic [63:0] mn, input logic [63:0] mx);
    chk({tag, "_sum"}, 64'(sum), s);
    chk({tag, "_sumsq"}, 64'(sumsq), sq);
    chk({tag, "_mean"}, 64'(mean), m);
    chk({tag, "_min"}, 64'(min_s), mn);
    chk({tag, "_max"}, 64'(max_s), mx);
  endtask

  initial begin
    rst = 1'b1; gr = '0; gr_valid = 1'b0; start = 1'b0; res_ack = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk_results("rst", 64'd0, 64'd0, 64'd0, 64'hFFF, 64'd0);
    rst = 1'b0;

    // Basic window 1,2,3,4; res_ack outside HOLD must be ignored.
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    pulse_start();
    chk("w1_busy", 64'(busy), 64'd1);
    smp(12'h001); smp(12'h002); smp(12'h003);
    chk("w1_notdone", 64'(res_valid), 64'd0);
    smp(12'h004);
    chk("w1_valid", 64'(res_valid), 64'd1);
    chk("w1_busy_off", 64'(busy), 64'd0);
    chk_results("w1", 64'd10, 64'd30, 64'd2, 64'd1, 64'd4);

    // HOLD ignores samples and start without ack.
    gr = 12'h007; gr_valid = 1'b1; start = 1'b1;
    tick();
    gr_valid = 1'b0; start = 1'b0;
    chk("hold_valid", 64'(res_valid), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);
    chk_results("hold", 64'd10, 64'd30, 64'd2, 64'd1, 64'd4);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("ack_valid", 64'(res_valid), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
    chk("idle_keep_sum", 64'(sum), 64'd10);

    // Full-scale samples with gr_valid every third cycle.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gap_busy_a", 64'(busy), 64'd1);
      tick();
      chk("gap_busy_b", 64'(busy), 64'd1);
      smp(12'hFFF);
    end
    chk("fs_valid", 64'(res_valid), 64'd1);
    chk_results("fs", 64'h3FFC, 64'h3FF8004, 64'hFFF, 64'hFFF, 64'hFFF);

    // Back-to-back: ack and start together.
    res_ack = 1'b1; start = 1'b1;
    tick();
    res_ack = 1'b0; start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_valid", 64'(res_valid), 64'd0);
    chk_results("b2b_clr", 64'd0, 64'd0, 64'd0, 64'hFFF, 64'd0);
    smp(12'h005); smp(12'h009); smp(12'h002); smp(12'h007);
    chk("b2b_done", 64'(res_valid), 64'd1);
    chk_results("b2b", 64'd23, 64'd159, 64'd5, 64'd2, 64'd9);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Abort mid-window with rst; start in ACC is ignored.
    pulse_start();
    smp(12'h003);
    start = 1'b1;
    smp(12'h004);
    start = 1'b0;
    chk("abort_pre_sum", 64'(sum), 64'd7);
    rst = 1'b1; gr = 12'h00A; gr_valid = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; gr_valid = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk_results("abort", 64'd0, 64'd0, 64'd0, 64'hFFF, 64'd0);
    smp(12'h00A); smp(12'h00A);
    chk("abort_idle_valid", 64'(res_valid), 64'd0);
    chk("abort_idle_sum", 64'(sum), 64'd0);

    pulse_start();
    smp(12'h008); smp(12'h008); smp(12'h008); smp(12'h008);
    chk("fresh_valid", 64'(res_valid), 64'd1);
    chk_results("fresh", 64'd32, 64'd256, 64'd8, 64'd8, 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
